// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default VGA 640x480 timing constants, count type and decode helper
package vga_pkg;

  localparam int CW = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int HT = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int VT = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [CW-1:0] count_t;

  function automatic logic in_span(input count_t c, input int lo, input int len);
    int ci;
    ci = int'(c);
    return (ci >= lo) && (ci < lo + len);
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel-advance enable and raster timing outputs
interface vga_if;
  import vga_pkg::*;

  logic   pix_en;
  count_t hc;
  count_t vc;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_start;

  modport master (
    input  pix_en,
    output hc, vc, hsync, vsync, video_on, frame_start
  );

  modport slave (
    output pix_en,
    input  hc, vc, hsync, vsync, video_on, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrap counter with enable and terminal count,
// plus sync/active flags registered from the next count so they line up with the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output count_t count,
  output logic   tc,
  output logic   sync_n,
  output logic   active
);

  localparam int     TOTAL = ACTIVE + FP + SYNC + BP;
  localparam count_t LAST  = count_t'(TOTAL - 1);

  count_t nxt;

  always_comb begin
    tc  = (count == LAST);
    nxt = tc ? '0 : count + count_t'(1);
  end

  // Reset parks on the last count so the first enabled edge lands on zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= LAST;
      sync_n <= 1'b1;
      active <= 1'b0;
    end else if (en) begin
      count  <= nxt;
      sync_n <= !in_span(nxt, ACTIVE + FP, SYNC);
      active <= in_span(nxt, 0, ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator (hc/vc, syncs, video_on, frame_start).
// Define VGA_INTERNAL_DIV_EN to advance from an internal divide-by-4 instead of pix_en.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  vga_if.master vga
);

  logic   adv;
  count_t h_count;
  count_t v_count;
  logic   h_tc;
  logic   v_tc;
  logic   h_sync_n;
  logic   v_sync_n;
  logic   h_active;
  logic   v_active;
  logic   frame_start;

`ifdef VGA_INTERNAL_DIV_EN
  logic [1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= 2'd0;
    end else begin
      div <= div + 2'd1;
    end
  end

  assign adv = (div == 2'd3);
`else
  assign adv = vga.pix_en;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .en     (adv),
    .count  (h_count),
    .tc     (h_tc),
    .sync_n (h_sync_n),
    .active (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .en     (adv & h_tc),
    .count  (v_count),
    .tc     (v_tc),
    .sync_n (v_sync_n),
    .active (v_active)
  );

  // Both counters wrap on the same edge, so this fires exactly on entry to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= adv & h_tc & v_tc;
    end
  end

  assign vga.hc          = h_count;
  assign vga.vc          = v_count;
  assign vga.hsync       = h_sync_n;
  assign vga.vsync       = v_sync_n;
  assign vga.video_on    = h_active & v_active;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - bench for vga_timing: default-size and reduced-size instances
// driven in lockstep and checked against a frame-position reference model.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
  localparam int SV_A = 10, SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int S_HT  = SH_A + SH_F + SH_S + SH_B;
  localparam int S_VT  = SV_A + SV_F + SV_S + SV_B;
  localparam int S_TOT = S_HT * S_VT;
  localparam int B_TOT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_if bus_b ();
  vga_if bus_s ();

  vga_timing dut_b (
    .clk (clk),
    .rst (rst),
    .vga (bus_b.master)
  );

  vga_timing #(
    .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
    .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vga (bus_s.master)
  );

  logic [23:0] act_b, act_s;
  assign act_b = {bus_b.hc, bus_b.vc, bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.frame_start};
  assign act_s = {bus_s.hc, bus_s.vc, bus_s.hsync, bus_s.vsync, bus_s.video_on, bus_s.frame_start};

  int n_cmp = 0;
  int n_bad = 0;
  int pb, ps;
  bit fb, fsm;
  int cyc = 0;
  int fs_last = -1;
  int fs_period = 0;

  typedef struct {
    bit          r;
    bit          en;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame position p counts advances since (0,0); everything else follows from it.
  function automatic logic [23:0] ref_vec(input int p, input int ht, input int ha, input int hf,
                                          input int hs, input int va, input int vf, input int vs,
                                          input bit fs);
    int h, v;
    logic [9:0] h10, v10;
    logic hsn, vsn, von;
    h   = p % ht;
    v   = p / ht;
    h10 = h[9:0];
    v10 = v[9:0];
    hsn = !((h >= ha + hf) && (h < ha + hf + hs));
    vsn = !((v >= va + vf) && (v < va + vf + vs));
    von = (h < ha) && (v < va);
    return {h10, v10, hsn, vsn, von, fs};
  endfunction

  task automatic step(input bit r, input bit en);
    @(negedge clk);
    rst = r;
    bus_b.pix_en = en;
    bus_s.pix_en = en;
    @(posedge clk);
    cyc++;
    if (r) begin
      pb = B_TOT - 1; ps = S_TOT - 1; fb = 1'b0; fsm = 1'b0;
    end else if (en) begin
      pb = (pb + 1) % B_TOT; ps = (ps + 1) % S_TOT;
      fb = (pb == 0); fsm = (ps == 0);
    end else begin
      fb = 1'b0; fsm = 1'b0;
    end
    #2;
    check("model_big", act_b, ref_vec(pb, HT, H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF,
                                      V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, fb));
    check("model_small", act_s, ref_vec(ps, S_HT, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, fsm));
    if (bus_s.frame_start) begin
      if (fs_last >= 0) fs_period = cyc - fs_last;
      fs_last = cyc;
    end
  endtask

  initial begin
    int hs_low, hs_first, hs_last, von_cnt, vs_low_s, von_s;
    bus_b.pix_en = 1'b0;
    bus_s.pix_en = 1'b0;
    pb = B_TOT - 1;
    ps = S_TOT - 1;
    fb = 1'b0;
    fsm = 1'b0;

    tbl[0] = '{r: 1'b1, en: 1'b0, exp: {10'd24, 10'd16, 4'b1100}};
    tbl[1] = '{r: 1'b1, en: 1'b1, exp: {10'd24, 10'd16, 4'b1100}};
    tbl[2] = '{r: 1'b0, en: 1'b0, exp: {10'd24, 10'd16, 4'b1100}};
    tbl[3] = '{r: 1'b0, en: 1'b1, exp: {10'd0,  10'd0,  4'b1111}};
    tbl[4] = '{r: 1'b0, en: 1'b1, exp: {10'd1,  10'd0,  4'b1110}};
    tbl[5] = '{r: 1'b0, en: 1'b0, exp: {10'd1,  10'd0,  4'b1110}};
    tbl[6] = '{r: 1'b0, en: 1'b1, exp: {10'd2,  10'd0,  4'b1110}};

    #1 rst = 1'b1;
    #1;
    check("reset_big", act_b, {10'd799, 10'd524, 4'b1100});
    check("reset_small", act_s, {10'd24, 10'd16, 4'b1100});

`ifdef VGA_INTERNAL_DIV_EN
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      int n_adv;
      logic [9:0] eh;
      @(posedge clk);
      #2;
      n_adv = k / 4;
      eh = (n_adv == 0) ? 10'd799 : 10'(n_adv - 1);
      check("div_hc", {22'd0, bus_b.hc}, {22'd0, eh});
      check("div_vc", {22'd0, bus_b.vc}, (n_adv == 0) ? 32'd524 : 32'd0);
    end
`else
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].en);
      check("table", act_s, tbl[i].exp);
    end

    // Continuous advance across a full default line and a full reduced frame.
    step(1'b1, 1'b0);
    fs_last = -1; fs_period = 0;
    hs_low = 0; hs_first = -1; hs_last = -1; von_cnt = 0; vs_low_s = 0; von_s = 0;
    for (int i = 0; i < 800; i++) begin
      step(1'b0, 1'b1);
      if (i == 0) check("first_edge", {bus_b.hc, bus_b.vc, bus_b.frame_start}, {10'd0, 10'd0, 1'b1});
      if (!bus_b.hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(bus_b.hc);
        hs_last = int'(bus_b.hc);
      end
      if (bus_b.video_on) von_cnt++;
      if (i < S_TOT) begin
        if (!bus_s.vsync) vs_low_s++;
        if (bus_s.video_on) von_s++;
      end
    end
    step(1'b0, 1'b1);
    check("after_800", {bus_b.hc, bus_b.vc}, {10'd0, 10'd1});
    check("hsync_width", hs_low, 96);
    check("hsync_first", hs_first, 656);
    check("hsync_last", hs_last, 751);
    check("video_on_line", von_cnt, 640);
    check("vsync_width_small", vs_low_s, SV_S * S_HT);
    check("video_on_frame_small", von_s, SH_A * SV_A);
    check("frame_period_cont", fs_period, S_TOT);

    // Advance on every 4th clock.
    step(1'b1, 1'b0);
    fs_last = -1; fs_period = 0;
    for (int i = 0; i < 3600; i++) step(1'b0, (i % 4) == 0);
    check("frame_period_div4", fs_period, 4 * S_TOT);

    // Random enables with occasional resets.
    step(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1);

    // Asynchronous reset mid-frame, away from any clock edge.
    step(1'b1, 1'b0);
    for (int i = 0; i < 1000 && ps != 8 * S_HT + 12; i++) step(1'b0, 1'b1);
    check("pos_12_8", {bus_s.hc, bus_s.vc}, {10'd12, 10'd8});
    @(negedge clk);
    bus_b.pix_en = 1'b1;
    bus_s.pix_en = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async_rst_big", act_b, {10'd799, 10'd524, 4'b1100});
    check("async_rst_small", act_s, {10'd24, 10'd16, 4'b1100});
    pb = B_TOT - 1; ps = S_TOT - 1; fb = 1'b0; fsm = 1'b0;
    step(1'b0, 1'b1);
    check("rst_release_small", act_s, {10'd0, 10'd0, 4'b1111});
    step(1'b0, 1'b1);
    check("fs_single_clk", {31'd0, bus_b.frame_start}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
